// File: rtl/draw_command_executor.sv
// draw_command_executor: executes one drawing command per go/done handshake,
// streaming one pixel per clock (row-major) to the VGA adapter write port and
// suppressing plot for pixels that fall outside the screen.
module draw_command_executor #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic       clk,
  input  logic       program_resetn,
  input  logic       go_draw_command,
  input  logic [1:0] cmd_type,
  input  logic [7:0] cmd_x,
  input  logic [6:0] cmd_y,
  input  logic [7:0] cmd_w,
  input  logic [6:0] cmd_h,
  input  logic [2:0] cmd_colour,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       done_draw_command,
  output logic [1:0] current_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DRAW = 2'd2, DONE = 2'd3} state_t;

  localparam logic [8:0] SW9 = 9'(SCREEN_W);
  localparam logic [7:0] SH8 = 8'(SCREEN_H);

  state_t     state_q, state_d;
  logic [7:0] x0_q, x0_d, w_q, w_d, cx_q, cx_d;
  logic [6:0] y0_q, y0_d, h_q, h_d, cy_q, cy_d;
  logic [2:0] col_q, col_d, colour_q, colour_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic       plot_q, plot_d, done_q, done_d;

  // Scratch values shared by the next-state logic.
  logic [7:0] eff_w, next_cx;
  logic [6:0] eff_h, next_cy;
  logic [8:0] sum_x;
  logic [7:0] sum_y;
  logic       col_end, last_pixel;

  // Next-state and next-output computation; every output is registered, so a
  // pixel is presented the cycle after the edge that selects it.
  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    w_d      = w_q;
    h_d      = h_q;
    col_d    = col_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    x_d      = 8'd0;
    y_d      = 7'd0;
    colour_d = 3'd0;
    plot_d   = 1'b0;
    done_d   = 1'b0;

    eff_w = cmd_type[0] ? cmd_w : 8'd1;
    eff_h = cmd_type[1] ? cmd_h : 7'd1;

    col_end    = (cx_q == w_q - 8'd1);
    last_pixel = col_end && (cy_q == h_q - 7'd1);
    next_cx    = col_end ? 8'd0 : cx_q + 8'd1;
    next_cy    = col_end ? cy_q + 7'd1 : cy_q;
    // Sums are one bit wider than the screen coordinates so that a pixel
    // past the right/bottom edge is clipped rather than wrapped.
    sum_x      = {1'b0, x0_q} + {1'b0, next_cx};
    sum_y      = {1'b0, y0_q} + {1'b0, next_cy};

    case (state_q)
      IDLE: begin
        if (go_draw_command) state_d = LOAD;
      end
      LOAD: begin
        if (!go_draw_command) begin
          state_d = IDLE;
        end else begin
          x0_d  = cmd_x;
          y0_d  = cmd_y;
          col_d = cmd_colour;
          w_d   = eff_w;
          h_d   = eff_h;
          cx_d  = 8'd0;
          cy_d  = 7'd0;
          if (eff_w == 8'd0 || eff_h == 7'd0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            // Pixel 0 is emitted straight from the command inputs.
            state_d  = DRAW;
            x_d      = cmd_x;
            y_d      = cmd_y;
            colour_d = cmd_colour;
            plot_d   = ({1'b0, cmd_x} < SW9) && ({1'b0, cmd_y} < SH8);
          end
        end
      end
      DRAW: begin
        if (!go_draw_command) begin
          state_d = IDLE;
        end else if (last_pixel) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          cx_d     = next_cx;
          cy_d     = next_cy;
          x_d      = sum_x[7:0];
          y_d      = sum_y[6:0];
          colour_d = col_q;
          plot_d   = (sum_x < SW9) && (sum_y < SH8);
        end
      end
      DONE: begin
        if (go_draw_command) done_d = 1'b1;
        else                 state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!program_resetn) begin
      state_q  <= IDLE;
      x0_q     <= 8'd0;
      y0_q     <= 7'd0;
      w_q      <= 8'd0;
      h_q      <= 7'd0;
      col_q    <= 3'd0;
      cx_q     <= 8'd0;
      cy_q     <= 7'd0;
      x_q      <= 8'd0;
      y_q      <= 7'd0;
      colour_q <= 3'd0;
      plot_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      w_q      <= w_d;
      h_q      <= h_d;
      col_q    <= col_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      done_q   <= done_d;
    end
  end

  assign x                 = x_q;
  assign y                 = y_q;
  assign colour            = colour_q;
  assign plot              = plot_q;
  assign done_draw_command = done_q;
  assign current_state     = state_q;

endmodule

// File: tb/tb_draw_command_executor.sv
// Scoreboard bench for draw_command_executor: the driver expands each command
// into the list of visible pixels (with the cycle each must appear) and the
// monitor pops that list whenever plot is high.
module tb_draw_command_executor;

  logic       clk = 1'b0;
  logic       program_resetn = 1'b0;
  logic       go_draw_command = 1'b0;
  logic [1:0] cmd_type = 2'd0;
  logic [7:0] cmd_x = 8'd0;
  logic [6:0] cmd_y = 7'd0;
  logic [7:0] cmd_w = 8'd0;
  logic [6:0] cmd_h = 7'd0;
  logic [2:0] cmd_colour = 3'd0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       done_draw_command;
  logic [1:0] current_state;

  draw_command_executor dut (
    .clk               (clk),
    .program_resetn    (program_resetn),
    .go_draw_command   (go_draw_command),
    .cmd_type          (cmd_type),
    .cmd_x             (cmd_x),
    .cmd_y             (cmd_y),
    .cmd_w             (cmd_w),
    .cmd_h             (cmd_h),
    .cmd_colour        (cmd_colour),
    .x                 (x),
    .y                 (y),
    .colour            (colour),
    .plot              (plot),
    .done_draw_command (done_draw_command),
    .current_state     (current_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int px;
    int py;
    int pc;
    int cyc;
  } pix_t;

  pix_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every plotted pixel must be the next expected one, on time.
  always @(negedge clk) begin
    if (plot) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_plot: got x=%0d y=%0d c=%0d expected no pixel (cycle %0d)",
                 x, y, colour, cyc);
      end else begin
        pix_t e;
        e = exp_q.pop_front();
        chk("pixel_xyc", (int'(x) << 16) | (int'(y) << 8) | int'(colour),
            (e.px << 16) | (e.py << 8) | e.pc);
        chk("pixel_cycle", cyc, e.cyc);
        $display("pixel x=%0d y=%0d colour=%0d cycle=%0d", x, y, colour, cyc);
      end
    end
  end

  // Issue one command, model its pixels, and check the done handshake.
  task automatic run_cmd(input logic [1:0] t, input int cx0, input int cy0,
                         input int w, input int h, input int col);
    int ew, eh, n, e0, exp_done, done_at;
    @(negedge clk);
    cmd_type   = t;
    cmd_x      = 8'(cx0);
    cmd_y      = 7'(cy0);
    cmd_w      = 8'(w);
    cmd_h      = 7'(h);
    cmd_colour = 3'(col);
    go_draw_command = 1'b1;
    e0 = cyc + 1;
    case (t)
      2'd0:    begin ew = 1; eh = 1; end
      2'd1:    begin ew = w; eh = 1; end
      2'd2:    begin ew = 1; eh = h; end
      default: begin ew = w; eh = h; end
    endcase
    n = ew * eh;
    for (int r = 0; r < eh; r++)
      for (int c = 0; c < ew; c++)
        if (cx0 + c < 160 && cy0 + r < 120)
          exp_q.push_back('{cx0 + c, cy0 + r, col, e0 + 1 + r * ew + c});
    exp_done = e0 + n + 1;
    done_at = -1;
    for (int i = 0; i < n + 8; i++) begin
      @(negedge clk);
      if (cyc >= e0 + 1) begin
        // Command inputs must be ignored after LOAD.
        cmd_type   = 2'($urandom);
        cmd_x      = 8'($urandom);
        cmd_y      = 7'($urandom);
        cmd_w      = 8'($urandom);
        cmd_h      = 7'($urandom);
        cmd_colour = 3'($urandom);
      end
      if (done_draw_command) begin
        done_at = cyc;
        break;
      end
    end
    $display("cmd type=%0d at (%0d,%0d) w=%0d h=%0d col=%0d pixels=%0d done_edge=E%0d",
             t, cx0, cy0, w, h, col, n, done_at - e0);
    chk("done_edge", done_at, exp_done);
    chk("done_state", int'(current_state), 3);
    @(negedge clk);
    chk("done_held", int'(done_draw_command), 1);
    go_draw_command = 1'b0;
    @(negedge clk);
    chk("idle_after_done", {int'(current_state), int'(done_draw_command), int'(plot)}, 0);
    chk("pixels_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // 10-pixel line cut short during its 3rd pixel by reset or by dropping go.
  task automatic abort_cmd(input bit use_reset);
    int e0;
    @(negedge clk);
    cmd_type = 2'd1; cmd_x = 8'd20; cmd_y = 7'd30; cmd_w = 8'd10; cmd_h = 7'd0;
    cmd_colour = 3'd5;
    go_draw_command = 1'b1;
    e0 = cyc + 1;
    for (int k = 0; k < 3; k++) exp_q.push_back('{20 + k, 30, 5, e0 + 1 + k});
    while (cyc < e0 + 3) @(negedge clk);
    if (use_reset) program_resetn = 1'b0;
    else           go_draw_command = 1'b0;
    @(negedge clk);
    $display("abort via %s at cycle %0d", use_reset ? "reset" : "go_low", cyc);
    chk(use_reset ? "reset_outputs" : "abort_outputs",
        int'({x, y, colour, plot, done_draw_command, current_state}), 0);
    program_resetn = 1'b1;
    go_draw_command = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done_draw_command) chk("no_done_after_abort", 1, 0);
    end
    chk("abort_pixels_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_state", int'({x, y, colour, plot, done_draw_command, current_state}), 0);
    program_resetn = 1'b1;
    @(negedge clk);
    chk("idle_state", int'({x, y, colour, plot, done_draw_command, current_state}), 0);

    run_cmd(2'd0, 5, 7, 0, 0, 4);       // single pixel
    run_cmd(2'd1, 10, 20, 4, 0, 2);     // horizontal line
    run_cmd(2'd3, 0, 0, 3, 2, 6);       // rectangle order
    run_cmd(2'd1, 158, 0, 4, 0, 7);     // right-edge clip
    run_cmd(2'd3, 0, 0, 0, 5, 1);       // zero width
    run_cmd(2'd2, 3, 117, 0, 6, 3);     // bottom-edge clip
    run_cmd(2'd2, 40, 40, 0, 0, 3);     // zero height
    abort_cmd(1'b1);
    abort_cmd(1'b0);

    for (int i = 0; i < 40; i++)
      run_cmd(2'($urandom), int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
              int'($urandom_range(0, 12)), int'($urandom_range(0, 8)),
              int'($urandom_range(0, 7)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
